// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit adder: one CHUNK-wide slice per stage, carry registered between stages.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             r_v [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];

    logic             w_vi  [STAGES];
    logic [WIDTH-1:0] w_ai  [STAGES];
    logic [WIDTH-1:0] w_bi  [STAGES];
    logic [WIDTH-1:0] w_si  [STAGES];
    logic             w_ci  [STAGES];
    logic [CHUNK:0]   w_add [STAGES];
    logic             w_adv;

    assign w_adv    = out_ready | ~r_v[LAST];
    assign in_ready = w_adv | rst;

    // Stage k adds chunk k; upper operand bits ride along untouched.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_vi[k] = in_valid;
                assign w_ai[k] = a;
                assign w_bi[k] = b;
                assign w_si[k] = '0;
                assign w_ci[k] = cin;
            end else begin : g_body
                assign w_vi[k] = r_v[k-1];
                assign w_ai[k] = r_a[k-1];
                assign w_bi[k] = r_b[k-1];
                assign w_si[k] = r_s[k-1];
                assign w_ci[k] = r_c[k-1];
            end
            assign w_add[k] = {1'b0, w_ai[k][k*CHUNK +: CHUNK]}
                            + {1'b0, w_bi[k][k*CHUNK +: CHUNK]}
                            + {{CHUNK{1'b0}}, w_ci[k]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i] <= 1'b0;
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_s[i] <= '0;
                r_c[i] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i] <= w_vi[i];
                r_a[i] <= w_ai[i];
                r_b[i] <= w_bi[i];
                r_s[i] <= w_si[i];
                r_s[i][i*CHUNK +: CHUNK] <= w_add[i][CHUNK-1:0];
                r_c[i] <= w_add[i][CHUNK];
            end
        end
    end

    assign out_valid = r_v[LAST];
    assign s         = r_s[LAST];
    assign cout      = r_c[LAST];

`ifdef ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Final chunk holds the sum MSB, so overflow is resolved in the last stage.
    assign w_ovf = (w_ai[LAST][WIDTH-1] == w_bi[LAST][WIDTH-1])
                 & (w_add[LAST][CHUNK-1] != w_ai[LAST][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Self-checking bench for pipelined_adder_nbit (WIDTH=16, STAGES=4).
// Queue-based arithmetic model, directed boundary vectors and random backpressure.
module tb_pipelined_adder_nbit;

    localparam int W  = 16;
    localparam int ST = 4;

    typedef logic [W+1:0] res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef ADDER_OVF_EN
    logic         ovf;
`endif

    pipelined_adder_nbit #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s(s),
        .cout(cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    res_t exp_q[$];
    res_t rx_q[$];
    int   rx_cyc[$];
    int   in_cyc[$];
    res_t hold;
    bit   held = 0;
    bit   done = 0;

    always @(posedge clk) cyc++;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
        logic [W:0] sum;
        logic       ov;
        sum = x + y + c;
        ov  = 1'b0;
`ifdef ADDER_OVF_EN
        ov  = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
`endif
        return {ov, sum};
    endfunction

    function automatic res_t dut_out();
        logic ov;
        ov = 1'b0;
`ifdef ADDER_OVF_EN
        ov = ovf;
`endif
        return {ov, cout, s};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 0;
        end else begin
            if (held) begin
                chk("hold_stable", dut_out(), hold);
                chk("hold_valid", out_valid, 1);
            end
            held = 0;
            if (out_valid && !out_ready) begin
                chk("in_ready_frozen", in_ready, 0);
                hold = dut_out();
                held = 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output got=%h want=none", dut_out());
                end else begin
                    chk("result", dut_out(), exp_q.pop_front());
                end
                rx_q.push_back(dut_out());
                rx_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin));
                in_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int n;
        n = 0;
        a = ta;
        b = tb;
        cin = tc;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got=in_ready_low want=accept");
                break;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
        end
        #1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_cyc.delete();
        in_cyc.delete();
    endtask

    logic [W-1:0] va[$];
    logic [W-1:0] vb[$];
    logic         vc[$];
    res_t         ve[$];

    task automatic add_vec(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic c, input res_t e);
        va.push_back(x);
        vb.push_back(y);
        vc.push_back(c);
        ve.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);

        chk("model_pin_ripple", model(16'hFFFF, 16'h0001, 1'b0), 18'h10000);
        chk("model_pin_max", model(16'hFFFF, 16'hFFFF, 1'b1), 18'h1FFFF);

        // Full ripple carry, exact latency.
        clear_rx();
        send(16'hFFFF, 16'h0001, 1'b0);
        step();
        step();
        chk("lat_not_early", out_valid, 0);
        step();
        chk("lat_valid", out_valid, 1);
        chk("lat_s", s, 16'h0000);
        chk("lat_cout", cout, 1);
        drain();

        // Back-to-back stream (i, 2i).
        clear_rx();
        for (int i = 0; i < 8; i++) send(16'(i), 16'(2 * i), 1'b0);
        drain();
        chk("stream_count", rx_q.size(), 8);
        if (rx_q.size() == 8 && in_cyc.size() == 8) begin
            chk("stream_latency", rx_cyc[0] - in_cyc[0], ST);
            for (int i = 0; i < 8; i++) begin
                chk("stream_sum", rx_q[i][W-1:0], 3 * i);
                chk("stream_consec", rx_cyc[i] - rx_cyc[0], i);
            end
        end

        // Backpressure during cycles 5-7.
        clear_rx();
        fork
            begin
                for (int i = 0; i < 4; i++) send(16'(100 + i), 16'(7 * i), i[0]);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", rx_q.size(), 4);
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk("bp_order", rx_q[i], model(16'(100 + i), 16'(7 * i), i[0]));
        end

        // Reset with three results in flight.
        clear_rx();
        for (int i = 0; i < 3; i++) send(16'h1111, 16'(i), 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        chk("rst_mid_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_s", s, 0);
        chk("rst_mid_cout", cout, 0);
        repeat (8) step();
        chk("rst_mid_silent", rx_q.size(), 0);

        // Boundary vectors with hand-computed results {ovf,cout,s}.
        clear_rx();
        add_vec(16'hFFFF, 16'hFFFF, 1'b1, 18'h1FFFF);
        add_vec(16'h0FFF, 16'h0001, 1'b0, 18'h01000);
        add_vec(16'h00FF, 16'hFF01, 1'b0, 18'h10000);
        add_vec(16'hF0F0, 16'h0F0F, 1'b1, 18'h10000);
        add_vec(16'h1234, 16'h4321, 1'b0, 18'h05555);
`ifdef ADDER_OVF_EN
        add_vec(16'h7FFF, 16'h0001, 1'b0, 18'h28000);
        add_vec(16'h8000, 16'h8000, 1'b0, 18'h30000);
        add_vec(16'h0001, 16'h0001, 1'b0, 18'h00002);
`endif
        foreach (va[i]) send(va[i], vb[i], vc[i]);
        drain();
        chk("vec_count", rx_q.size(), va.size());
        if (rx_q.size() == va.size()) begin
            foreach (ve[i]) chk("vec_literal", rx_q[i], ve[i]);
        end

        // Random traffic with random backpressure.
        clear_rx();
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
                    if ($urandom_range(0, 7) == 0) rb = 16'hFFFF - ra;
                    send(ra, rb, 1'($urandom));
                    repeat ($urandom_range(0, 2)) step();
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("rand_count", rx_q.size(), 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
